// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage hazard controller bus: decoder fields, writeback, branch resolution and
// the issue/stall/flush decision coming back.
interface decode_hazard_ctrl_if #(
    parameter int unsigned REG_ADDRESS_SIZE = 5
);
    logic                        dec_valid;
    logic [REG_ADDRESS_SIZE-1:0] dec_addr_r1;
    logic                        dec_use_r1;
    logic [REG_ADDRESS_SIZE-1:0] dec_addr_r2;
    logic                        dec_use_r2;
    logic [REG_ADDRESS_SIZE-1:0] dec_addr_rd;
    logic                        dec_we;
    logic                        dec_branch;
    logic                        wb_valid;
    logic [REG_ADDRESS_SIZE-1:0] wb_addr_rd;
    logic                        br_resolved;
    logic                        br_taken;
    logic                        issue;
    logic                        stall;
    logic                        flush;
    logic [1:0]                  state;
    logic                        sb_err;

    modport master (
        output dec_valid, dec_addr_r1, dec_use_r1, dec_addr_r2, dec_use_r2,
               dec_addr_rd, dec_we, dec_branch, wb_valid, wb_addr_rd,
               br_resolved, br_taken,
        input  issue, stall, flush, state, sb_err
    );

    modport slave (
        input  dec_valid, dec_addr_r1, dec_use_r1, dec_addr_r2, dec_use_r2,
               dec_addr_rd, dec_we, dec_branch, wb_valid, wb_addr_rd,
               br_resolved, br_taken,
        output issue, stall, flush, state, sb_err
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: pending-write scoreboard, issue/stall decision, branch hold/flush.
// Optional macro HAZ_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module decode_hazard_ctrl #(
    parameter int unsigned REG_ADDRESS_SIZE = 5,
    parameter int unsigned PEND_W           = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_hazard_ctrl_if.slave  bus
);

    localparam int unsigned     NREG    = 2 ** REG_ADDRESS_SIZE;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

`ifdef HAZ_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PEND_W-1:0]   count_q [NREG];
    logic                sb_err_q;

    logic [PEND_W-1:0]   cnt_r1;
    logic [PEND_W-1:0]   cnt_r2;
    logic [PEND_W-1:0]   cnt_rd;
    logic                wb_hit_r1;
    logic                wb_hit_r2;
    logic                wb_hit_rd;
    logic                busy_r1;
    logic                busy_r2;
    logic                full_rd;
    logic                hazard;
    logic                issue_c;
    logic                stall_c;
    logic                flush_c;
    logic                inc_en;
    logic                dec_en;

    assign cnt_r1 = count_q[bus.dec_addr_r1];
    assign cnt_r2 = count_q[bus.dec_addr_r2];
    assign cnt_rd = count_q[bus.dec_addr_rd];

    // A retiring write to the same register only relieves a hazard when bypass is built in
    assign wb_hit_r1 = WB_BYPASS && bus.wb_valid && (bus.wb_addr_rd == bus.dec_addr_r1);
    assign wb_hit_r2 = WB_BYPASS && bus.wb_valid && (bus.wb_addr_rd == bus.dec_addr_r2);
    assign wb_hit_rd = WB_BYPASS && bus.wb_valid && (bus.wb_addr_rd == bus.dec_addr_rd);

    assign busy_r1 = (bus.dec_addr_r1 != '0) && (cnt_r1 != '0)
                     && !(wb_hit_r1 && (cnt_r1 == CNT_ONE));
    assign busy_r2 = (bus.dec_addr_r2 != '0) && (cnt_r2 != '0)
                     && !(wb_hit_r2 && (cnt_r2 == CNT_ONE));
    assign full_rd = bus.dec_we && (bus.dec_addr_rd != '0) && (cnt_rd == CNT_MAX) && !wb_hit_rd;

    assign hazard = (bus.dec_use_r1 && busy_r1) || (bus.dec_use_r2 && busy_r2) || full_rd;

    assign inc_en = issue_c && bus.dec_we && (bus.dec_addr_rd != '0);
    assign dec_en = bus.wb_valid && (bus.wb_addr_rd != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (issue_c && bus.dec_branch) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolved) begin
                    state_d = bus.br_taken ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Issue/stall/flush decode; all quiet while reset is asserted
    always_comb begin
        issue_c = 1'b0;
        stall_c = 1'b0;
        flush_c = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    issue_c = bus.dec_valid && !hazard;
                    stall_c = bus.dec_valid && hazard;
                end
                ST_BR_WAIT: stall_c = 1'b1;
                ST_FLUSH:   flush_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Pending-write counters; a same-register issue and retire cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                count_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (dec_en && (count_q[bus.wb_addr_rd] == '0)) begin
                sb_err_q <= 1'b1;
            end
            if (!(inc_en && dec_en && (bus.dec_addr_rd == bus.wb_addr_rd))) begin
                if (inc_en) begin
                    count_q[bus.dec_addr_rd] <= count_q[bus.dec_addr_rd] + CNT_ONE;
                end
                if (dec_en && (count_q[bus.wb_addr_rd] != '0)) begin
                    count_q[bus.wb_addr_rd] <= count_q[bus.wb_addr_rd] - CNT_ONE;
                end
            end
        end
    end

    assign bus.issue  = issue_c;
    assign bus.stall  = stall_c;
    assign bus.flush  = flush_c;
    assign bus.state  = 2'(state_q);
    assign bus.sb_err = sb_err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: directed scenarios plus random traffic checked
// against a counter/state reference model.
module tb_decode_hazard_ctrl;

    localparam int unsigned RAS  = 5;
    localparam int          MAXC = 3;
    localparam int          S_RUN = 0;
    localparam int          S_BRW = 1;
    localparam int          S_FL  = 2;

`ifdef HAZ_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit rst; bit v;
        int r1;  bit u1;
        int r2;  bit u2;
        int rd;  bit we; bit br;
        bit wbv; int wba;
        bit res; bit tkn;
    } in_t;

    typedef struct {
        bit iss; bit stl; bit fl; int st; bit err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_hazard_ctrl_if #(.REG_ADDRESS_SIZE(RAS)) bus ();
    decode_hazard_ctrl #(.REG_ADDRESS_SIZE(RAS), .PEND_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   cnt [32];
    int   st;
    bit   err;
    exp_t expq [$];
    in_t  prev;
    int   total = 0;
    int   bad   = 0;

    function automatic in_t idle();
        in_t v;
        v = '{rst:0, v:0, r1:0, u1:0, r2:0, u2:0, rd:0, we:0, br:0,
              wbv:0, wba:0, res:0, tkn:0};
        return v;
    endfunction

    function automatic bit m_busy(input int r, input in_t v);
        if (r == 0 || cnt[r] == 0) return 1'b0;
        if (BYP && cnt[r] == 1 && v.wbv && v.wba == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_hazard(input in_t v);
        bit full;
        full = v.we && v.rd != 0 && cnt[v.rd] == MAXC && !(BYP && v.wbv && v.wba == v.rd);
        return (v.u1 && m_busy(v.r1, v)) || (v.u2 && m_busy(v.r2, v)) || full;
    endfunction

    function automatic bit m_issue(input in_t v);
        return !v.rst && v.v && st == S_RUN && !m_hazard(v);
    endfunction

    function automatic exp_t m_out(input in_t v);
        exp_t e;
        e.st  = st;
        e.err = err;
        if (v.rst) begin
            e.iss = 0; e.stl = 0; e.fl = 0;
        end else begin
            e.iss = m_issue(v);
            e.stl = (st == S_RUN && v.v && m_hazard(v)) || st == S_BRW;
            e.fl  = (st == S_FL);
        end
        return e;
    endfunction

    // Advance the model across one clock edge using the inputs held before it
    task automatic model_edge(input in_t p);
        bit iss;
        bit inc;
        bit dec;
        if (p.rst) begin
            foreach (cnt[i]) cnt[i] = 0;
            st  = S_RUN;
            err = 1'b0;
            return;
        end
        iss = m_issue(p);
        inc = iss && p.we && p.rd != 0;
        dec = p.wbv && p.wba != 0;
        if (dec && cnt[p.wba] == 0) err = 1'b1;
        if (!(inc && dec && p.rd == p.wba)) begin
            if (inc) cnt[p.rd] = cnt[p.rd] + 1;
            if (dec && cnt[p.wba] > 0) cnt[p.wba] = cnt[p.wba] - 1;
        end
        case (st)
            S_RUN:   if (iss && p.br) st = S_BRW;
            S_BRW:   if (p.res) st = p.tkn ? S_FL : S_RUN;
            default: st = S_RUN;
        endcase
    endtask

    task automatic drive(input in_t v);
        reset           = v.rst;
        bus.dec_valid   = v.v;
        bus.dec_addr_r1 = 5'(v.r1);
        bus.dec_use_r1  = v.u1;
        bus.dec_addr_r2 = 5'(v.r2);
        bus.dec_use_r2  = v.u2;
        bus.dec_addr_rd = 5'(v.rd);
        bus.dec_we      = v.we;
        bus.dec_branch  = v.br;
        bus.wb_valid    = v.wbv;
        bus.wb_addr_rd  = 5'(v.wba);
        bus.br_resolved = v.res;
        bus.br_taken    = v.tkn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge(prev);
    endtask

    task automatic apply(input in_t v);
        drive(v);
        expq.push_back(m_out(v));
        prev = v;
    endtask

    task automatic step(input in_t v);
        tick();
        apply(v);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: the DUT presents a decision every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("issue",  int'(bus.issue),  int'(e.iss));
                chk("stall",  int'(bus.stall),  int'(e.stl));
                chk("flush",  int'(bus.flush),  int'(e.fl));
                chk("state",  int'(bus.state),  e.st);
                chk("sb_err", int'(bus.sb_err), int'(e.err));
            end
        end
    end

    initial begin
        in_t v;
        in_t w;
        int  r;
        prev     = idle();
        prev.rst = 1'b1;
        drive(prev);
        foreach (cnt[i]) cnt[i] = 0;
        st  = S_RUN;
        err = 1'b0;

        // Reset held with a valid instruction present
        v = idle(); v.rst = 1; v.v = 1; v.r1 = 5; v.u1 = 1; v.rd = 4; v.we = 1;
        repeat (2) step(v);

        // RAW on r5
        v = idle(); v.v = 1; v.rd = 5; v.we = 1;
        step(v);
        v = idle(); v.v = 1; v.r1 = 5; v.u1 = 1;
        repeat (2) step(v);
        w = v; w.wbv = 1; w.wba = 5;
        step(w);
        repeat (2) step(v);

        // Saturation on r7
        v = idle(); v.v = 1; v.rd = 7; v.we = 1;
        repeat (3) step(v);
        repeat (2) step(v);
        w = v; w.wbv = 1; w.wba = 7;
        step(w);
        step(v);
        w = idle(); w.wbv = 1; w.wba = 7;
        repeat (3) step(w);
        step(idle());

        // Taken branch
        v = idle(); v.v = 1; v.br = 1;
        step(v);
        v = idle(); v.v = 1; v.rd = 2; v.we = 1;
        repeat (3) step(v);
        w = v; w.res = 1; w.tkn = 1;
        step(w);
        repeat (2) step(idle());

        // Not-taken branch, then same-cycle issue and retire on r3
        v = idle(); v.v = 1; v.br = 1;
        step(v);
        w = idle(); w.res = 1; w.tkn = 0;
        step(idle());
        step(w);
        v = idle(); v.v = 1; v.rd = 3; v.we = 1;
        step(v);
        w = v; w.wbv = 1; w.wba = 3;
        step(w);
        v = idle(); v.v = 1; v.r1 = 3; v.u1 = 1;
        step(v);
        w = idle(); w.wbv = 1; w.wba = 3;
        step(w);
        step(v);

        // Randomized traffic on a small register window
        repeat (1500) begin
            tick();
            v = idle();
            v.v  = ($urandom_range(0, 3) != 0);
            v.r1 = $urandom_range(0, 7); v.u1 = $urandom_range(0, 1);
            v.r2 = $urandom_range(0, 7); v.u2 = $urandom_range(0, 1);
            v.rd = $urandom_range(0, 7); v.we = $urandom_range(0, 1);
            v.br = ($urandom_range(0, 7) == 0);
            r = $urandom_range(1, 7);
            if (cnt[r] > 0 && $urandom_range(0, 1) == 1) begin
                v.wbv = 1; v.wba = r;
            end
            v.res = ($urandom_range(0, 2) == 0);
            v.tkn = $urandom_range(0, 1);
            v.rst = ($urandom_range(0, 199) == 0);
            apply(v);
        end

        // Reset during a branch wait must not produce a flush
        v = idle(); v.rst = 1;
        repeat (2) step(v);
        v = idle(); v.v = 1; v.br = 1;
        step(v);
        step(idle());
        v = idle(); v.rst = 1;
        step(v);
        w = idle(); w.res = 1; w.tkn = 1;
        repeat (3) step(w);

        // r0 is never counted; stray writeback raises a sticky error
        v = idle(); v.v = 1; v.rd = 0; v.we = 1;
        repeat (4) step(v);
        v = idle(); v.v = 1; v.r1 = 0; v.u1 = 1; v.r2 = 0; v.u2 = 1; v.rd = 0; v.we = 1;
        step(v);
        w = idle(); w.wbv = 1; w.wba = 9;
        step(w);
        repeat (4) step(idle());
        v = idle(); v.rst = 1;
        repeat (2) step(v);
        repeat (2) step(idle());

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
